pipe_controller: RTL
====================

PIPE_CONTROLLER -- requirements
Module: pipe_controller

Interface
REQ-001 Parameter ALUOP_W, default 4, ALU op field width; SHALL be >= 4, with upper bits zero-extended.
REQ-002 Parameter HAZARD_EN, default 1; when 0, load-use detection SHALL be disabled.
REQ-003 Parameter LINK_REG, default 31, jal destination register.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  reset, asynchronous assert and active-low.
REQ-006 instr_id  input  32  instruction in ID.
REQ-007 id_valid  input  1  instr_id holds a real instruction.
REQ-008 ex_branch_taken  input  1  branch resolved taken in EX.
REQ-009 stall_ext  input  1  external memory stall; freezes the whole pipe.
REQ-010 pc_write, ifid_write, ifid_flush  output  1 each  fetch/IF-ID control.
REQ-011 id_jump  output  1  combinational; j/jal valid in ID.
REQ-012 ex_valid, ex_reg_imm, ex_branch, ex_branch_ne, ex_jr  output  1 each; ex_alu_op  output  ALUOP_W.
REQ-013 mem_valid, mem_read, mem_write, mem_regwrite  output  1 each; mem_wreg  output  5.
REQ-014 wb_valid, wb_regwrite, wb_memtoreg, wb_jal  output  1 each; wb_wreg  output  5.
REQ-015 illegal_instr  output  1  registered; valid alongside ex_valid.

Function
REQ-016 ALU codes SHALL be: add=1, sub=2, and=3, or=4, xor=5, nor=6, slt=7, sll=8, srl=9; bubble=0.
REQ-017 R-type (opcode 0) funct decode SHALL be: 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x26 xor, 0x27 nor, 0x2A slt, 0x00 sll, 0x02 srl (all regwrite, wreg=rd); 0x08 jr (ex_jr=1, no regwrite).
REQ-018 I/J decode SHALL be: 0x08 addi add; 0x0C andi and; 0x0A slti slt (reg_imm=1, regwrite, wreg=rt); 0x04 beq sub+branch; 0x05 bne sub+branch+branch_ne; 0x23 lw add+reg_imm+read+memtoreg+regwrite, wreg=rt; 0x2B sw add+reg_imm+write; 0x02 j; 0x03 jal (regwrite, wb_jal, wreg=LINK_REG).
REQ-019 Any other opcode/funct with id_valid=1 SHALL enter EX as a bubble with illegal_instr=1 for its EX cycle.
REQ-020 regwrite SHALL be forced to 0 when wreg=0.
REQ-021 Latency: ID at cycle n -> EX outputs n+1, MEM n+2, WB n+3, absent stalls.
REQ-022 Bubble SHALL mean every control output 0 and valid 0.
REQ-023 Load-use: HAZARD_EN=1, ex_valid, mem_read pending in EX, EX wreg != 0 and equal to ID rs, or to ID rt for R-type/beq/bne/sw -> pc_write=0, ifid_write=0, bubble into EX; EX->MEM->WB advance.
REQ-024 Flush: ex_valid and (ex_branch_taken or ex_jr) -> ifid_flush=1, bubble into EX, pc_write=1.
REQ-025 id_jump=1 -> ifid_flush=1 next edge; the j/jal itself SHALL proceed into EX.
REQ-026 Priority SHALL be stall_ext > flush > load-use > jump.
REQ-027 stall_ext=1 -> all stage registers hold, pc_write=0, ifid_write=0, ifid_flush=0, id_jump=0; the held EX branch SHALL re-assert flush once stall_ext drops.
REQ-028 id_valid=0 SHALL insert a bubble and never trigger hazard or jump.

Reset
REQ-029 rst_n low SHALL asynchronously clear all stage registers to bubble and illegal_instr to 0; pc_write=1, ifid_write=1, ifid_flush=0.
REQ-030 Reset mid-operation SHALL discard all in-flight instructions; the first post-release edge SHALL capture ID normally.

Verification
REQ-031 add $3,$1,$2 at cycle 0 -> cycle 1 ex_alu_op=1; cycle 2 mem_regwrite=1, mem_wreg=3; cycle 3 wb_regwrite=1, wb_wreg=3.
REQ-032 lw $5,0($1) then add $6,$5,$2 -> one cycle pc_write=0/ifid_write=0, EX bubble, add in EX one cycle later; with HAZARD_EN=0 -> no stall.
REQ-033 beq in EX with ex_branch_taken=1 while stall_ext=1 -> no flush; stall_ext drops -> ifid_flush=1, next ex_valid=0.
REQ-034 jal at ID -> id_jump=1, ifid_flush=1; WB three cycles later: wb_jal=1, wb_wreg=31.
REQ-035 opcode 0x3F -> ex_valid=0, illegal_instr=1 for one cycle; addi $0 -> mem_regwrite=0.
REQ-036 rst_n pulsed low between clock edges with three instructions in flight -> all valid outputs 0 immediately.

Source files
------------

// File: rtl/pipe_controller.sv
// rtl/pipe_controller.sv - five-stage pipeline control: ID decode, EX/MEM/WB control registers, hazard/flush/stall
// Priority of pipe events is stall_ext > flush > load-use > jump.
module pipe_controller #(
  parameter int          ALUOP_W   = 4,
  parameter bit          HAZARD_EN = 1'b1,
  parameter logic [4:0]  LINK_REG  = 5'd31
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [31:0]        instr_id,
  input  logic               id_valid,
  input  logic               ex_branch_taken,
  input  logic               stall_ext,
  output logic               pc_write,
  output logic               ifid_write,
  output logic               ifid_flush,
  output logic               id_jump,
  output logic               ex_valid,
  output logic               ex_reg_imm,
  output logic               ex_branch,
  output logic               ex_branch_ne,
  output logic               ex_jr,
  output logic [ALUOP_W-1:0] ex_alu_op,
  output logic               mem_valid,
  output logic               mem_read,
  output logic               mem_write,
  output logic               mem_regwrite,
  output logic [4:0]         mem_wreg,
  output logic               wb_valid,
  output logic               wb_regwrite,
  output logic               wb_memtoreg,
  output logic               wb_jal,
  output logic [4:0]         wb_wreg,
  output logic               illegal_instr
);

  localparam logic [3:0] ALU_NOP = 4'd0, ALU_ADD = 4'd1, ALU_SUB = 4'd2, ALU_AND = 4'd3,
                         ALU_OR  = 4'd4, ALU_XOR = 4'd5, ALU_NOR = 4'd6, ALU_SLT = 4'd7,
                         ALU_SLL = 4'd8, ALU_SRL = 4'd9;

  typedef struct packed {
    logic               valid;
    logic               reg_imm;
    logic               branch;
    logic               branch_ne;
    logic               jr;
    logic               mem_read;
    logic               mem_write;
    logic               memtoreg;
    logic               regwrite;
    logic               jal;
    logic [4:0]         wreg;
    logic [ALUOP_W-1:0] alu_op;
  } ex_t;

  typedef struct packed {
    logic       valid;
    logic       read;
    logic       write;
    logic       regwrite;
    logic       memtoreg;
    logic       jal;
    logic [4:0] wreg;
  } mem_t;

  typedef struct packed {
    logic       valid;
    logic       regwrite;
    logic       memtoreg;
    logic       jal;
    logic [4:0] wreg;
  } wb_t;

  ex_t  ex_q, ex_d, dec;
  mem_t mem_q, mem_d;
  wb_t  wb_q, wb_d;
  logic illegal_q, illegal_d;

  logic [5:0] opcode, funct;
  logic [4:0] rs, rt, rd;
  logic [3:0] alu;
  logic       legal, uses_rt, is_jump;
  logic       flush, load_use;
  logic       unused_shamt;

  assign opcode       = instr_id[31:26];
  assign rs           = instr_id[25:21];
  assign rt           = instr_id[20:16];
  assign rd           = instr_id[15:11];
  assign funct        = instr_id[5:0];
  assign unused_shamt = ^instr_id[10:6];

  always_comb begin
    dec     = '0;
    alu     = ALU_NOP;
    legal   = 1'b1;
    uses_rt = 1'b0;
    is_jump = 1'b0;
    case (opcode)
      6'h00: begin
        uses_rt      = 1'b1;
        dec.regwrite = 1'b1;
        dec.wreg     = rd;
        case (funct)
          6'h20: alu = ALU_ADD;
          6'h22: alu = ALU_SUB;
          6'h24: alu = ALU_AND;
          6'h25: alu = ALU_OR;
          6'h26: alu = ALU_XOR;
          6'h27: alu = ALU_NOR;
          6'h2A: alu = ALU_SLT;
          6'h00: alu = ALU_SLL;
          6'h02: alu = ALU_SRL;
          6'h08: begin
            dec.jr       = 1'b1;
            dec.regwrite = 1'b0;
            dec.wreg     = 5'd0;
          end
          default: legal = 1'b0;
        endcase
      end
      6'h08, 6'h0C, 6'h0A: begin
        alu          = (opcode == 6'h08) ? ALU_ADD : (opcode == 6'h0C) ? ALU_AND : ALU_SLT;
        dec.reg_imm  = 1'b1;
        dec.regwrite = 1'b1;
        dec.wreg     = rt;
      end
      6'h04, 6'h05: begin
        alu           = ALU_SUB;
        uses_rt       = 1'b1;
        dec.branch    = 1'b1;
        dec.branch_ne = opcode[0];
      end
      6'h23: begin
        alu          = ALU_ADD;
        dec.reg_imm  = 1'b1;
        dec.mem_read = 1'b1;
        dec.memtoreg = 1'b1;
        dec.regwrite = 1'b1;
        dec.wreg     = rt;
      end
      6'h2B: begin
        alu           = ALU_ADD;
        uses_rt       = 1'b1;
        dec.reg_imm   = 1'b1;
        dec.mem_write = 1'b1;
      end
      6'h02: is_jump = 1'b1;
      6'h03: begin
        is_jump      = 1'b1;
        dec.regwrite = 1'b1;
        dec.jal      = 1'b1;
        dec.wreg     = LINK_REG;
      end
      default: legal = 1'b0;
    endcase
    dec.valid  = 1'b1;
    dec.alu_op = ALUOP_W'(alu);
    // A write to $0 is architecturally a no-op.
    if (dec.wreg == 5'd0) dec.regwrite = 1'b0;
  end

  assign flush    = ex_q.valid && (ex_branch_taken || ex_q.jr);
  assign load_use = HAZARD_EN && ex_q.valid && ex_q.mem_read && (ex_q.wreg != 5'd0) && id_valid &&
                    ((ex_q.wreg == rs) || (uses_rt && (ex_q.wreg == rt)));

  always_comb begin
    pc_write   = 1'b1;
    ifid_write = 1'b1;
    ifid_flush = 1'b0;
    id_jump    = 1'b0;
    if (rst_n) begin
      if (stall_ext) begin
        pc_write   = 1'b0;
        ifid_write = 1'b0;
      end else if (flush) begin
        ifid_flush = 1'b1;
      end else if (load_use) begin
        pc_write   = 1'b0;
        ifid_write = 1'b0;
      end else if (id_valid && legal && is_jump) begin
        id_jump    = 1'b1;
        ifid_flush = 1'b1;
      end
    end
  end

  always_comb begin
    ex_d      = ex_q;
    mem_d     = mem_q;
    wb_d      = wb_q;
    illegal_d = illegal_q;
    if (!stall_ext) begin
      wb_d.valid     = mem_q.valid;
      wb_d.regwrite  = mem_q.regwrite;
      wb_d.memtoreg  = mem_q.memtoreg;
      wb_d.jal       = mem_q.jal;
      wb_d.wreg      = mem_q.wreg;
      mem_d.valid    = ex_q.valid;
      mem_d.read     = ex_q.mem_read;
      mem_d.write    = ex_q.mem_write;
      mem_d.regwrite = ex_q.regwrite;
      mem_d.memtoreg = ex_q.memtoreg;
      mem_d.jal      = ex_q.jal;
      mem_d.wreg     = ex_q.wreg;
      ex_d           = '0;
      illegal_d      = 1'b0;
      if (id_valid && !flush && !load_use) begin
        if (legal) ex_d = dec;
        else illegal_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q      <= '0;
      mem_q     <= '0;
      wb_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      ex_q      <= ex_d;
      mem_q     <= mem_d;
      wb_q      <= wb_d;
      illegal_q <= illegal_d;
    end
  end

  assign ex_valid      = ex_q.valid;
  assign ex_reg_imm    = ex_q.reg_imm;
  assign ex_branch     = ex_q.branch;
  assign ex_branch_ne  = ex_q.branch_ne;
  assign ex_jr         = ex_q.jr;
  assign ex_alu_op     = ex_q.alu_op;
  assign mem_valid     = mem_q.valid;
  assign mem_read      = mem_q.read;
  assign mem_write     = mem_q.write;
  assign mem_regwrite  = mem_q.regwrite;
  assign mem_wreg      = mem_q.wreg;
  assign wb_valid      = wb_q.valid;
  assign wb_regwrite   = wb_q.regwrite;
  assign wb_memtoreg   = wb_q.memtoreg;
  assign wb_jal        = wb_q.jal;
  assign wb_wreg       = wb_q.wreg;
  assign illegal_instr = illegal_q;

endmodule
